// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: data-hazard / forwarding unit beside the ID stage.
// Tracks in-flight writers in a shift table (entry k = instruction in stage k),
// raises load-use style stalls and per-operand forward selects, and counts
// stall cycles for performance analysis.
module hazard_scoreboard #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 5,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic [SEL_W-1:0] id_ready,
  input  logic             flush_id,
  input  logic             stat_clr,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  // Table storage; array index i holds table entry k = i+1.
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0]            ent_wr_en;
  logic [DEPTH-1:0][REG_W-1:0] ent_dest;
  logic [DEPTH-1:0][SEL_W-1:0] ent_ready;

  logic id_live;
  logic rs_haz;
  logic rt_haz;
  logic rs_found;
  logic rt_found;

  assign id_live     = id_valid & ~flush_id;
  assign stall       = id_live & (rs_haz | rt_haz);
  assign stage_valid = ent_valid;

  // Shift table: older stages always advance, entry 1 takes ID or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_wr_en <= '0;
      ent_dest  <= '0;
      ent_ready <= '0;
    end else begin
      for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_wr_en[i] <= ent_wr_en[i-1];
        ent_dest[i]  <= ent_dest[i-1];
        ent_ready[i] <= ent_ready[i-1];
      end
      ent_valid[0] <= id_live & ~stall;
      ent_wr_en[0] <= id_live & ~stall & id_wr_en;
      ent_dest[0]  <= id_dest;
      ent_ready[0] <= id_ready;
    end
  end

  // Youngest-match search per operand; a not-yet-ready producer is a hazard.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    rs_haz     = 1'b0;
    rt_haz     = 1'b0;
    rs_found   = 1'b0;
    rt_found   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rs_found && id_use_rs && (id_rs != '0) && ent_valid[i] &&
          ent_wr_en[i] && (ent_dest[i] == id_rs)) begin
        rs_found = 1'b1;
        if (ent_ready[i] > SEL_W'(i + 1)) rs_haz = 1'b1;
        else fwd_rs_sel = SEL_W'(i + 1);
      end
      if (!rt_found && id_use_rt && (id_rt != '0) && ent_valid[i] &&
          ent_wr_en[i] && (ent_dest[i] == id_rt)) begin
        rt_found = 1'b1;
        if (ent_ready[i] > SEL_W'(i + 1)) rt_haz = 1'b1;
        else fwd_rt_sel = SEL_W'(i + 1);
      end
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver applies directed and random
// ID traffic, predicts the response from an instruction-level pipeline model
// and queues it; a monitor pops and compares on every falling edge.
module tb_hazard_scoreboard;

  localparam int unsigned D  = 5;
  localparam int unsigned RW = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 3;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs = '0;
  logic [RW-1:0] id_rt = '0;
  logic          id_use_rs = 1'b0;
  logic          id_use_rt = 1'b0;
  logic          id_wr_en = 1'b0;
  logic [RW-1:0] id_dest = '0;
  logic [SW-1:0] id_ready = SW'(1);
  logic          flush_id = 1'b0;
  logic          stat_clr = 1'b0;
  logic          stall;
  logic [SW-1:0] fwd_rs_sel;
  logic [SW-1:0] fwd_rt_sel;
  logic [D-1:0]  stage_valid;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(.DEPTH(D), .REG_W(RW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_dest(id_dest), .id_ready(id_ready), .flush_id(flush_id),
    .stat_clr(stat_clr), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction-level model of the pipeline behind ID.
  typedef struct {
    bit v;
    bit we;
    int dest;
    int rdy;
  } instr_t;

  typedef struct {
    int stall;
    int rs_sel;
    int rt_sel;
    int sv;
    int cnt;
  } exp_t;

  instr_t pipe[1:D];
  int     m_cnt   = 0;
  bit     m_stall = 1'b0;
  exp_t   sbq[$];
  int     n_vec   = 0;
  int     n_cmp   = 0;
  int     n_bad   = 0;

  // Which stage (if any) supplies this register, and is it ready there.
  function automatic void lookup(input bit use_it, input int r,
                                 output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (use_it && r != 0) begin
      for (int k = 1; k <= D; k++) begin
        if (pipe[k].v && pipe[k].we && pipe[k].dest == r) begin
          if (pipe[k].rdy > k) haz = 1'b1;
          else sel = k;
          return;
        end
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   hrs, hrt;
    bit   live;
    live = id_valid && !flush_id;
    lookup(id_use_rs, int'(id_rs), e.rs_sel, hrs);
    lookup(id_use_rt, int'(id_rt), e.rt_sel, hrt);
    e.stall = (live && (hrs || hrt)) ? 1 : 0;
    e.sv = 0;
    for (int k = 1; k <= D; k++) if (pipe[k].v) e.sv += (1 << (k - 1));
    e.cnt = m_cnt;
    return e;
  endfunction

  function automatic void model_clear();
    for (int k = 1; k <= D; k++) pipe[k] = '{v: 1'b0, we: 1'b0, dest: 0, rdy: 0};
    m_cnt = 0;
  endfunction

  // One ID cycle: advance the model across the edge, apply new inputs, predict.
  task automatic step(input bit rst, input bit v, input bit fl, input bit clr,
                      input int rs, input int rt, input bit urs, input bit urt,
                      input bit we, input int dst, input int rdy);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int k = D; k >= 2; k--) pipe[k] = pipe[k-1];
      if (id_valid && !flush_id && !m_stall)
        pipe[1] = '{v: 1'b1, we: id_wr_en, dest: int'(id_dest), rdy: int'(id_ready)};
      else
        pipe[1] = '{v: 1'b0, we: 1'b0, dest: 0, rdy: 0};
      if (stat_clr) m_cnt = 0;
      else if (m_stall && m_cnt < CNT_MAX) m_cnt++;
    end
    rst_n     = rst;
    id_valid  = v;
    flush_id  = fl;
    stat_clr  = clr;
    id_rs     = RW'(rs);
    id_rt     = RW'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wr_en  = we;
    id_dest   = RW'(dst);
    id_ready  = SW'(rdy);
    if (!rst) model_clear();
    e = predict();
    m_stall = (e.stall != 0);
    sbq.push_back(e);
    n_vec++;
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic ins(input int rs, input int rt, input bit urs, input bit urt,
                     input bit we, input int dst, input int rdy);
    step(1, 1, 0, 0, rs, rt, urs, urt, we, dst, rdy);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, n_cmp, act, exp_v);
    end
  endtask

  // Monitor: outputs are live every cycle; compare away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", int'(stall), e.stall);
        chk("fwd_rs_sel", int'(fwd_rs_sel), e.rs_sel);
        chk("fwd_rt_sel", int'(fwd_rt_sel), e.rt_sel);
        chk("stage_valid", int'(stage_valid), e.sv);
        chk("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    bit urs, urt, we;
    int rs, rt, dst, rdy, pick;
    model_clear();
    // reset, then idle after release
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(); nop();
    // back-to-back ALU and forwarding from progressively older stages
    ins(1, 2, 1, 1, 1, 3, 1);
    ins(3, 3, 1, 1, 1, 4, 1);
    ins(3, 0, 1, 0, 1, 9, 1);
    ins(0, 3, 0, 1, 1, 10, 1);
    ins(3, 3, 1, 1, 0, 0, 1);
    nop(); nop();
    ins(3, 3, 1, 1, 0, 0, 1);
    // load-use: one stall, then forward from MEM
    ins(1, 0, 1, 0, 1, 5, 2);
    ins(5, 0, 1, 0, 1, 6, 1);
    ins(5, 0, 1, 0, 1, 6, 1);
    // reset asserted mid-stall, then released
    ins(1, 0, 1, 0, 1, 5, 2);
    ins(5, 0, 1, 0, 1, 6, 1);
    step(0, 1, 0, 0, 5, 0, 1, 0, 1, 6, 1);
    step(0, 1, 0, 0, 5, 0, 1, 0, 1, 6, 1);
    nop(); nop();
    // youngest writer wins; $0 never matches
    ins(1, 0, 1, 0, 1, 7, 1);
    ins(2, 0, 1, 0, 1, 7, 1);
    ins(7, 7, 1, 1, 0, 0, 1);
    ins(1, 0, 1, 0, 1, 0, 3);
    ins(0, 0, 1, 1, 1, 11, 1);
    // flush beats stall
    ins(1, 0, 1, 0, 1, 8, 2);
    step(1, 1, 1, 0, 8, 8, 1, 1, 1, 12, 1);
    nop();
    // long-latency producer directly ahead
    ins(1, 0, 1, 0, 1, 13, 4);
    repeat (4) ins(13, 0, 1, 0, 1, 14, 1);
    // counter saturation then clear
    repeat (2) begin
      ins(1, 0, 1, 0, 1, 15, 5);
      repeat (5) ins(0, 15, 0, 1, 1, 16, 1);
    end
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    nop();
    // random traffic; ID holds its instruction while stalled
    rs = 0; rt = 0; urs = 0; urt = 0; we = 0; dst = 0; rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall) begin
        rs  = int'($urandom_range(0, 7));
        rt  = int'($urandom_range(0, 7));
        urs = ($urandom_range(0, 3) != 0);
        urt = ($urandom_range(0, 1) != 0);
        we  = ($urandom_range(0, 4) != 0);
        dst = int'($urandom_range(0, 7));
        pick = int'($urandom_range(0, 7));
        rdy = (pick < 4) ? 1 : (pick < 6) ? 2 : int'($urandom_range(1, D));
      end
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
           rs, rt, urs, urt, we, dst, rdy);
    end
    nop();
    // let the monitor drain, bounded
    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
